// File: rtl/isa_pkg.sv
// Shared ISA constants: word/address sizes, instruction field layout, sequencer states.
// Pure declarations, no logic; imported by the sequencer, its bench and the datapath.
package isa_pkg;

    localparam int IW    = 20;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;

    // Instruction word layout, MSB first: rr1 | rr2 | reg_we | alu_op | ram_addr | ram_we
    localparam int RR1_LSB      = 16;
    localparam int RR1_W        = 4;
    localparam int RR2_LSB      = 12;
    localparam int RR2_W        = 4;
    localparam int REG_WE_BIT   = 11;
    localparam int ALU_OP_LSB   = 8;
    localparam int ALU_OP_W     = 3;
    localparam int RAM_ADDR_LSB = 1;
    localparam int RAM_ADDR_W   = 7;
    localparam int RAM_WE_BIT   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/instr_sequencer_if.sv
// Issue bus from sequencer to datapath: offered word, its address, valid/ready.
// Master drives instr/instr_valid/pc; slave drives instr_ready.
interface instr_sequencer_if #(
    parameter int IW = isa_pkg::IW,
    parameter int AW = isa_pkg::AW
);
    import isa_pkg::*;

    logic [IW-1:0] instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [AW-1:0] pc;

    modport master (output instr, output instr_valid, output pc, input instr_ready);
    modport slave  (input instr, input instr_valid, input pc, output instr_ready);

endinterface

// File: rtl/instr_mem.sv
// Program store: DEPTH x IW array, synchronous write, asynchronous read.
// Read data is combinational from raddr; no backpressure.
module instr_mem #(
    parameter int IW    = 20,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues program-store words 0..last_addr in order over valid/ready, then pulses done.
// First word valid 1 cycle after start; offered word held stable until accepted or halted.
module instr_sequencer #(
    parameter int IW    = isa_pkg::IW,
    parameter int AW    = isa_pkg::AW,
    parameter int DEPTH = isa_pkg::DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_we,
    input  logic [AW-1:0]             load_addr,
    input  logic [IW-1:0]             load_data,
    input  logic                      start,
    input  logic [AW-1:0]             last_addr,
    input  logic                      halt,
    output logic                      busy,
    output logic                      done,
    instr_sequencer_if.master         bus
);
    import isa_pkg::*;

    seq_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] last_q, last_d;
    logic [IW-1:0] instr_q, instr_d;
    logic          vld_q, vld_d;
    logic          mem_we;
    logic          xfer;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] rd_data;

    // Prefetch address: word 0 when launching a run, otherwise the word after the one offered.
    assign rd_addr = (state_q == RUN) ? pc_q + AW'(1) : '0;

    instr_mem #(
        .IW    (IW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we & ~rst),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        last_d  = last_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        mem_we  = 1'b0;
        xfer    = vld_q & bus.instr_ready;
        case (state_q)
            IDLE: begin
                if (load_we) begin
                    mem_we = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    instr_d = rd_data;
                    vld_d   = 1'b1;
                    last_d  = last_addr;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (pc_q == last_q) begin
                        vld_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        pc_d    = pc_q + AW'(1);
                        instr_d = rd_data;
                    end
                end
                // A coincident transfer still advances pc above; halt only drops valid.
                if (halt) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            last_q  <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = vld_q;
    assign bus.pc          = pc_q;
    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction issuer for the ISA datapath. It holds a small program store of 20-bit instruction words and issues them in order over a valid/ready handshake, one word per accepted transfer. It sits upstream of the datapath and drives the datapath's `instruccion` input. Words are loaded through a write port while the block is idle; on `start` it issues words 0..`last_addr`, then pulses `done` and returns to idle.

## Interface
- `IW`, default 20: instruction word width.
- `AW`, default 5: program-store address width.
- `DEPTH`, default 32: program-store entries, equal to 2**AW.

Ports:
- `clk`: in, 1 bit. Single clock; all state updates on its rising edge.
- `rst`: in, 1 bit. Reset is synchronous and active-high.
- `load_we`: in, 1 bit. Program-store write enable; honoured only in IDLE.
- `load_addr`: in, AW bits. Program-store write address.
- `load_data`: in, IW bits. Instruction word to write.
- `start`: in, 1 bit. Begin issuing; sampled only in IDLE.
- `last_addr`: in, AW bits. Address of the final word. Sampled and held when `start` is accepted.
- `halt`: in, 1 bit. Abort issuing; sampled only in RUN.
- `instr`: out, IW bits. Instruction word currently offered.
- `instr_valid`: out, 1 bit. `instr` is valid.
- `instr_ready`: in, 1 bit. Consumer accepts `instr` this cycle.
- `pc`: out, AW bits. Address of the word currently offered.
- `busy`: out, 1 bit. High in RUN.
- `done`: out, 1 bit. One-cycle pulse after the last word is accepted.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- Reset values: `instr`=0, `instr_valid`=0, `pc`=0, `busy`=0, `done`=0, held `last_addr`=0. Program-store contents are not reset.
- IDLE:
  - `load_we`=1 writes `load_data` to `mem[load_addr]`.
  - `start`=1 with `load_we`=0 moves to RUN and sets `pc`<=0, `instr`<=`mem[0]`, `instr_valid`<=1, and latches `last_addr`.
  - If `start` and `load_we` are both high in the same cycle, the write is performed and `start` is ignored.
- RUN:
  - A transfer occurs when `instr_valid` and `instr_ready` are both high.
  - On a transfer with `pc` != held last: `pc`<=`pc`+1, `instr`<=`mem[pc+1]`, and `instr_valid` stays 1. There are no bubbles.
  - On a transfer with `pc` == held last: `instr_valid`<=0, state<=DONE.
  - With no transfer, `instr` and `pc` hold stable. A valid word is never withdrawn or changed while unaccepted, except by `halt` or `rst`.
  - `halt`=1: `instr_valid`<=0, state<=IDLE, and no `done`. If `halt` coincides with a transfer, the transfer completes and then the block goes to IDLE.
  - `load_we` is ignored in RUN and DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE.
- `pc` increments modulo 2**AW. Because of the `last_addr` check it never wraps during a run; `last_addr`=DEPTH-1 issues all 32 words.
- `last_addr`=0 issues exactly one word.
- `rst` asserted mid-RUN: next cycle all outputs take their reset values and the offered word is dropped.

## Timing
- Latency from `start` to first `instr_valid` is 1 cycle.
- Sustained throughput is 1 word/cycle while `instr_ready`=1.
- From the final transfer edge, `done` rises 1 cycle later.
- A program of N words with `instr_ready` held high takes `start` + N + 1 (DONE) cycles to return to IDLE.
- `instr` and `instr_valid` are registered outputs. `instr_ready` has no combinational path to any output.
- Program-store read is asynchronous, into the `instr` register. Write is synchronous.

## Structure
- Shared package `isa_pkg` holds:
  - `IW`, `AW` and `DEPTH`.
  - Instruction-field offsets/widths: read register 1, read register 2, register write enable, ALU op, RAM address, RAM write enable.
  - The state enum {IDLE, RUN, DONE}.
- The sequencer is field-agnostic. The package constants are for benches and the datapath.
- Sub-module `instr_mem`: DEPTH×IW array with one synchronous write port and one asynchronous read port. The FSM, `pc`, the output register and the handshake stay in `instr_sequencer`.

## Test plan
- **Basic run.** Load mem[0..3] = 0x12345, 0x0ABCD, 0xFFFFF, 0x00001; `last_addr`=3; `start`; `instr_ready`=1.
  - Required: the 4 words appear on consecutive cycles with `pc` 0..3, `done` pulses once, and the block returns to IDLE.
- **Backpressure.** Same program; `instr_ready` toggles 1,0,0,1,...
  - Required: `instr` and `pc` stay stable while `instr_ready`=0, no word is skipped or duplicated, and exactly 4 transfers occur.
- **Edge sizes.**
  - `last_addr`=0: exactly one transfer (mem[0]), then `done`.
  - `last_addr`=31 with mem[i]=i: 32 transfers of values 0..31, with no wrap to 0.
- **Halt.**
  - `halt` at `pc`=2 with no transfer that cycle: `instr_valid` falls next cycle, `done` never pulses, IDLE.
  - `halt` coinciding with the transfer at `pc`=2: the word at `pc`=2 is counted as transferred, then the block goes to IDLE.
- **Load/start collision.** mem[0]=0x00000; `load_we`=1, `load_addr`=0, `load_data`=0x55555 and `start`=1 in the same cycle.
  - Required: no run starts. A following `start` issues 0x55555.
  - `load_we` during RUN leaves mem unchanged.
- **Reset mid-run.** Assert `rst` while `instr_valid`=1 at `pc`=1.
  - Required: next cycle `instr_valid`=0, `pc`=0, `busy`=0, `done`=0.
  - A subsequent `start` replays from mem[0] with the contents preserved.
